// File: rtl/multiplier_sequencer_if.sv
// Operand/result handshake bundle between a producer/consumer and the
// multiplier sequencer.
//   inValid/inReady/inA/inB            : operand pair, valid/ready
//   outValid/outReady/outProduct/
//   outOverflow/outError               : registered result, valid/ready
// master = producer/consumer side, slave = sequencer side.
interface multiplier_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] outProduct;
  logic             outOverflow;
  logic             outError;

  modport master (
    output inValid, inA, inB, outReady,
    input  inReady, outValid, outProduct, outOverflow, outError
  );

  modport slave (
    input  inValid, inA, inB, outReady,
    output inReady, outValid, outProduct, outOverflow, outError
  );
endinterface

// File: rtl/multiplier_sequencer.sv
// Upstream controller for the register-wrapped multiplier. Accepts an
// operand pair, steps the multiplier through load / read inputs / write
// output / read output, captures product, overflow and access-error status,
// and holds one registered result until the consumer takes it.
// Ports:
//   clk, reset          : clock (rising edge), async active-high reset
//   bus (slave)         : operand and result valid/ready handshakes
//   mulA, mulB          : operands to the multiplier, registered at accept
//   mulWriteEnable*/mulReadEnable*/mulReset* : multiplier register controls
//   mulProduct, mulOverflow, mulAccessError* : multiplier status inputs
//   busy                : high whenever not idle
//   opCount             : number of results delivered, wrapping
module multiplier_sequencer #(
  parameter int WIDTH       = 32,
  parameter int WAIT_CYCLES = 1,
  parameter int ERR_ABORT   = 1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  multiplier_sequencer_if.slave bus,
  output logic [WIDTH-1:0]     mulA,
  output logic [WIDTH-1:0]     mulB,
  output logic                 mulWriteEnableA,
  output logic                 mulWriteEnableB,
  output logic                 mulReadEnableA,
  output logic                 mulReadEnableB,
  output logic                 mulWriteEnableOut,
  output logic                 mulReadEnableOut,
  output logic                 mulResetA,
  output logic                 mulResetB,
  output logic                 mulResetOut,
  input  logic [WIDTH-1:0]     mulProduct,
  input  logic                 mulOverflow,
  input  logic                 mulAccessErrorA,
  input  logic                 mulAccessErrorB,
  input  logic                 mulAccessErrorOut,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] opCount
);

  typedef enum logic [2:0] {
    IDLE, LOAD, COMPUTE, CAPTURE, READ, RESP, ABORT
  } state_t;

  state_t         state, next_state;
  logic [3:0]     cnt;
  logic           err_flag;
  logic           any_err;
  logic           in_seq;
  logic [WIDTH-1:0] prod_q;
  logic           ovf_q;

  assign any_err = mulAccessErrorA | mulAccessErrorB | mulAccessErrorOut;
  assign in_seq  = (state == LOAD) || (state == COMPUTE) ||
                   (state == CAPTURE) || (state == READ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.inValid) next_state = LOAD;
      LOAD:    next_state = COMPUTE;
      COMPUTE: if (cnt == '0) next_state = CAPTURE;
      CAPTURE: next_state = READ;
      READ:    if (cnt == '0) next_state = RESP;
      RESP:    if (bus.outReady) next_state = IDLE;
      ABORT:   next_state = RESP;
      default: next_state = IDLE;
    endcase
    if ((ERR_ABORT != 0) && in_seq && any_err) next_state = ABORT;
  end

  // Moore enable decode: exactly one group per state.
  always_comb begin
    mulWriteEnableA   = 1'b0;
    mulWriteEnableB   = 1'b0;
    mulReadEnableA    = 1'b0;
    mulReadEnableB    = 1'b0;
    mulWriteEnableOut = 1'b0;
    mulReadEnableOut  = 1'b0;
    mulResetA         = 1'b0;
    mulResetB         = 1'b0;
    mulResetOut       = 1'b0;
    case (state)
      LOAD:    begin mulWriteEnableA = 1'b1; mulWriteEnableB = 1'b1; end
      COMPUTE: begin mulReadEnableA  = 1'b1; mulReadEnableB  = 1'b1; end
      CAPTURE: mulWriteEnableOut = 1'b1;
      READ:    mulReadEnableOut  = 1'b1;
      ABORT:   begin mulResetA = 1'b1; mulResetB = 1'b1; mulResetOut = 1'b1; end
      default: ;
    endcase
  end

  assign bus.inReady     = (state == IDLE);
  assign bus.outValid    = (state == RESP);
  assign busy            = (state != IDLE);
  assign bus.outProduct  = prod_q;
  assign bus.outOverflow = ovf_q;
  assign bus.outError    = err_flag;

  // cnt is shared: WAIT_CYCLES-1 down to 0 in COMPUTE, then 1 down to 0 in READ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mulA     <= '0;
      mulB     <= '0;
      cnt      <= '0;
      err_flag <= 1'b0;
      prod_q   <= '0;
      ovf_q    <= 1'b0;
      opCount  <= '0;
    end else begin
      if (state == IDLE && bus.inValid) begin
        mulA     <= bus.inA;
        mulB     <= bus.inB;
        err_flag <= 1'b0;
      end
      if (in_seq && any_err) err_flag <= 1'b1;
      case (state)
        LOAD:    cnt <= 4'(WAIT_CYCLES - 1);
        COMPUTE: if (cnt != '0) cnt <= cnt - 1'b1;
        CAPTURE: cnt <= 4'd1;
        READ:    if (cnt != '0) cnt <= cnt - 1'b1;
        default: ;
      endcase
      if (state == READ && next_state == RESP) begin
        prod_q <= mulProduct;
        ovf_q  <= mulOverflow;
      end
      if (state == ABORT) begin
        prod_q <= '0;
        ovf_q  <= 1'b0;
      end
      if (state == RESP && bus.outReady) opCount <= opCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_multiplier_sequencer.sv
module tb_multiplier_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multiplier_sequencer_if #(.WIDTH(32)) if1 ();
  multiplier_sequencer_if #(.WIDTH(32)) if3 ();

  logic [31:0] mulA1, mulB1, prod1, mulA3, mulB3, prod3;
  logic wa1, wb1, ra1, rb1, wo1, ro1, rsa1, rsb1, rso1, ovf1, busy1;
  logic wa3, wb3, ra3, rb3, wo3, ro3, rsa3, rsb3, rso3, ovf3, busy3;
  logic ea1, eb1, eo1;
  logic zero3;
  logic [15:0] cnt1, cnt3;
  logic [8:0] en1;
  logic signed [63:0] p1, p3;

  assign zero3 = 1'b0;
  assign en1 = {wa1, wb1, ra1, rb1, wo1, ro1, rsa1, rsb1, rso1};

  // Behavioural multiplier: low 32 bits of the signed product, overflow when
  // the full product does not fit in 32 signed bits.
  always_comb begin
    p1    = 64'($signed(mulA1)) * 64'($signed(mulB1));
    prod1 = p1[31:0];
    ovf1  = (p1 != {{32{p1[31]}}, p1[31:0]});
    p3    = 64'($signed(mulA3)) * 64'($signed(mulB3));
    prod3 = p3[31:0];
    ovf3  = (p3 != {{32{p3[31]}}, p3[31:0]});
  end

  multiplier_sequencer #(.WIDTH(32), .WAIT_CYCLES(1), .ERR_ABORT(1), .CNT_WIDTH(16)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave),
    .mulA(mulA1), .mulB(mulB1),
    .mulWriteEnableA(wa1), .mulWriteEnableB(wb1),
    .mulReadEnableA(ra1), .mulReadEnableB(rb1),
    .mulWriteEnableOut(wo1), .mulReadEnableOut(ro1),
    .mulResetA(rsa1), .mulResetB(rsb1), .mulResetOut(rso1),
    .mulProduct(prod1), .mulOverflow(ovf1),
    .mulAccessErrorA(ea1), .mulAccessErrorB(eb1), .mulAccessErrorOut(eo1),
    .busy(busy1), .opCount(cnt1)
  );

  multiplier_sequencer #(.WIDTH(32), .WAIT_CYCLES(3), .ERR_ABORT(1), .CNT_WIDTH(16)) dut3 (
    .clk(clk), .reset(reset), .bus(if3.slave),
    .mulA(mulA3), .mulB(mulB3),
    .mulWriteEnableA(wa3), .mulWriteEnableB(wb3),
    .mulReadEnableA(ra3), .mulReadEnableB(rb3),
    .mulWriteEnableOut(wo3), .mulReadEnableOut(ro3),
    .mulResetA(rsa3), .mulResetB(rsb3), .mulResetOut(rso3),
    .mulProduct(prod3), .mulOverflow(ovf3),
    .mulAccessErrorA(zero3), .mulAccessErrorB(zero3), .mulAccessErrorOut(zero3),
    .busy(busy3), .opCount(cnt3)
  );

  localparam logic [8:0] EN_NONE = 9'b000000000;
  localparam logic [8:0] EN_LOAD = 9'b110000000;
  localparam logic [8:0] EN_COMP = 9'b001100000;
  localparam logic [8:0] EN_CAPT = 9'b000010000;
  localparam logic [8:0] EN_READ = 9'b000001000;
  localparam logic [8:0] EN_ABRT = 9'b000000111;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
    logic        o;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation on dut1 (WAIT_CYCLES=1), checking every phase.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ep, input logic eo,
                       input bit hold, input int stall, input string tag);
    int g;
    logic [31:0] p_hold;
    if1.inA = a;
    if1.inB = b;
    if1.inValid = 1'b1;
    if1.outReady = (stall == 0);
    g = 0;
    while (!if1.inReady && g < 20) begin
      step();
      g++;
    end
    chk($sformatf("%s ready", tag), if1.inReady, 1);
    step();
    if (!hold) if1.inValid = 1'b0;
    chk($sformatf("%s load", tag), en1, EN_LOAD);
    chk($sformatf("%s busy", tag), {busy1, if1.inReady}, 2'b10);
    step();
    chk($sformatf("%s comp", tag), en1, EN_COMP);
    step();
    chk($sformatf("%s capt", tag), en1, EN_CAPT);
    step();
    chk($sformatf("%s rd1", tag), en1, EN_READ);
    step();
    chk($sformatf("%s rd2", tag), en1, EN_READ);
    chk($sformatf("%s rd2 nv", tag), if1.outValid, 0);
    step();
    chk($sformatf("%s resp", tag), {if1.outValid, if1.inReady, en1}, {2'b10, EN_NONE});
    chk($sformatf("%s prod", tag), if1.outProduct, ep);
    chk($sformatf("%s ovf", tag), {if1.outOverflow, if1.outError}, {eo, 1'b0});
    p_hold = if1.outProduct;
    if (stall > 0) begin
      for (int i = 1; i < stall; i++) begin
        step();
        chk($sformatf("%s hold%0d", tag, i),
            {if1.outValid, if1.inReady, if1.outOverflow, if1.outProduct},
            {2'b10, eo, p_hold});
      end
      if1.outReady = 1'b1;
    end
    step();
    exp_cnt++;
    chk($sformatf("%s post", tag), {if1.outValid, if1.inReady}, 2'b01);
    chk($sformatf("%s count", tag), cnt1, exp_cnt);
  endtask

  initial begin
    int g, nr, lat, k;
    bit seen;
    logic [31:0] e;

    vt[0] = '{a: -2111,    b: -552233, p: 1165763863, o: 1'b0};
    vt[1] = '{a: 502,      b: -4,      p: -2008,      o: 1'b0};
    vt[2] = '{a: -2111,    b: 125,     p: -263875,    o: 1'b0};
    vt[3] = '{a: 12345678, b: 0,       p: 0,          o: 1'b0};
    vt[4] = '{a: -7,       b: 1,       p: -7,         o: 1'b0};
    vt[5] = '{a: 65536,    b: 65536,   p: 0,          o: 1'b1};

    reset = 1'b1;
    if1.inValid = 1'b0; if1.inA = '0; if1.inB = '0; if1.outReady = 1'b0;
    if3.inValid = 1'b0; if3.inA = '0; if3.inB = '0; if3.outReady = 1'b0;
    ea1 = 1'b0; eb1 = 1'b0; eo1 = 1'b0;
    step();
    step();
    chk("rst ready/valid", {if1.inReady, if1.outValid, busy1}, 3'b100);
    chk("rst enables", en1, EN_NONE);
    chk("rst result", {if1.outProduct, if1.outOverflow, if1.outError}, 34'd0);
    chk("rst count", cnt1, 0);
    chk("rst dut3", {if3.inReady, if3.outValid, busy3, cnt3}, {3'b100, 16'd0});
    reset = 1'b0;
    step();

    // Reset arriving in CAPTURE drops everything immediately.
    if1.inA = 5; if1.inB = 6; if1.inValid = 1'b1; if1.outReady = 1'b1;
    step();
    if1.inValid = 1'b0;
    step();
    step();
    chk("t5 capt", en1, EN_CAPT);
    #2 reset = 1'b1;
    #1;
    chk("t5 en drop", en1, EN_NONE);
    chk("t5 state", {if1.inReady, if1.outValid, busy1}, 3'b100);
    step();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (if1.outValid) seen = 1'b1;
    end
    chk("t5 no valid", seen, 0);
    chk("t5 after", {if1.inReady, cnt1}, {1'b1, 16'd0});

    // Basic op with overflow.
    do_op(32'd211819911, 32'd12345, 32'd3576685327, 1'b1, 1'b0, 0, "t1");

    // Back-to-back with inValid held.
    for (int i = 0; i < 6; i++)
      do_op(vt[i].a, vt[i].b, vt[i].p, vt[i].o, (i != 5), 0, $sformatf("t2v%0d", i));

    // Consumer stalls 7 cycles in RESP.
    do_op(1000, -3, -3000, 1'b0, 1'b0, 7, "t3");

    // Access error in COMPUTE aborts the op.
    if1.inA = -9; if1.inB = 7; if1.inValid = 1'b1; if1.outReady = 1'b1;
    step();
    if1.inValid = 1'b0;
    chk("t4 load", en1, EN_LOAD);
    step();
    chk("t4 comp", en1, EN_COMP);
    eb1 = 1'b1;
    step();
    eb1 = 1'b0;
    chk("t4 abort", en1, EN_ABRT);
    chk("t4 abort busy", {busy1, if1.outValid}, 2'b10);
    step();
    chk("t4 resets off", en1, EN_NONE);
    chk("t4 resp", {if1.outValid, if1.outError, if1.outOverflow}, 3'b110);
    chk("t4 prod", if1.outProduct, 0);
    step();
    exp_cnt++;
    chk("t4 count", {if1.outValid, cnt1}, {1'b0, 16'(exp_cnt)});
    do_op(-9, 7, -63, 1'b0, 1'b0, 0, "t4clean");

    // WAIT_CYCLES=3 instance.
    if3.inA = 100; if3.inB = -5; if3.inValid = 1'b1; if3.outReady = 1'b1;
    g = 0;
    while (!if3.inReady && g < 20) begin
      step();
      g++;
    end
    step();
    if3.inValid = 1'b0;
    nr = 0;
    lat = 0;
    k = 0;
    while (lat == 0 && k < 20) begin
      step();
      k++;
      if (ra3 && rb3) nr++;
      if (if3.outValid) lat = k;
    end
    chk("t6 read cycles", nr, 3);
    chk("t6 latency", lat, 7);
    e = -500;
    chk("t6 prod", if3.outProduct, e);
    step();
    chk("t6 count", {if3.outValid, cnt3}, {1'b0, 16'd1});

    chk("final count", cnt1, exp_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
